// File: rtl/ddr3_wr_burst_ctrl_if.sv
// FIFO-read and MIG app/wdf signals of the DDR3 write burst controller.
// master = burst controller side, slave = FIFO + MIG side.
interface ddr3_wr_burst_ctrl_if #(
  parameter int DATA_WD = 512,
  parameter int ADDR_WD = 28,
  parameter int CNT_WD  = 6
);
  // FWFT FIFO read side
  logic [DATA_WD-1:0] i_fifo_dout;
  logic               i_fifo_empty;
  logic [CNT_WD-1:0]  i_fifo_rd_cnt;
  logic               o_fifo_rd;
  // MIG command channel
  logic [2:0]         o_app_cmd;
  logic [ADDR_WD-1:0] o_app_addr;
  logic               o_app_en;
  logic               i_app_rdy;
  // MIG write-data channel
  logic [DATA_WD-1:0] o_app_wdf_data;
  logic               o_app_wdf_wren;
  logic               o_app_wdf_end;
  logic               i_app_wdf_rdy;

  modport master (
    input  i_fifo_dout, i_fifo_empty, i_fifo_rd_cnt, i_app_rdy, i_app_wdf_rdy,
    output o_fifo_rd, o_app_cmd, o_app_addr, o_app_en,
           o_app_wdf_data, o_app_wdf_wren, o_app_wdf_end
  );

  modport slave (
    output i_fifo_dout, i_fifo_empty, i_fifo_rd_cnt, i_app_rdy, i_app_wdf_rdy,
    input  o_fifo_rd, o_app_cmd, o_app_addr, o_app_en,
           o_app_wdf_data, o_app_wdf_wren, o_app_wdf_end
  );
endinterface

// File: rtl/ddr3_wr_burst_ctrl.sv
// DDR3 write burst controller: drains the FWFT width-conversion FIFO into the
// MIG native interface in bursts of BURST_LEN beats (or a shorter flush burst),
// walking a circular address region [base, end). One beat = one command plus
// one wdf beat, both accepted in the same cycle straight from the FIFO head.
module ddr3_wr_burst_ctrl #(
  parameter int DATA_WD   = 512,
  parameter int ADDR_WD   = 28,
  parameter int CNT_WD    = 6,
  parameter int BURST_LEN = 16,
  parameter int ADDR_STEP = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic               i_addr_load,
  input  logic [ADDR_WD-1:0] i_base_addr,
  input  logic [ADDR_WD-1:0] i_end_addr,
  ddr3_wr_burst_ctrl_if.master bus,
  output logic               o_busy,
  output logic               o_wrap,
  output logic [31:0]        o_beat_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [CNT_WD-1:0]  BURST_LEN_C = CNT_WD'(BURST_LEN);
  localparam logic [CNT_WD-1:0]  ONE_C       = CNT_WD'(1);
  localparam logic [ADDR_WD:0]   STEP_C      = (ADDR_WD+1)'(ADDR_STEP);

  state_t              state_q, state_d;
  logic [CNT_WD-1:0]   len_q, len_d;     // beats in the current burst
  logic [CNT_WD-1:0]   beat_q, beat_d;   // beats accepted so far in this burst
  logic [ADDR_WD-1:0]  addr_q;
  logic [ADDR_WD:0]    addr_nxt;         // one extra bit so the end compare never overflows
  logic                wrap_hit;
  logic                wrap_q;
  logic [31:0]         beat_tot_q;
  logic                fire;
  logic                last_beat;

  // A beat moves only when the FIFO has a head word and MIG takes both
  // command and data in the same cycle; no skid buffering anywhere.
  assign fire      = (state_q == BURST) & ~bus.i_fifo_empty & bus.i_app_rdy & bus.i_app_wdf_rdy;
  assign last_beat = fire && (beat_q == (len_q - ONE_C));

  assign addr_nxt  = {1'b0, addr_q} + STEP_C;
  assign wrap_hit  = (addr_nxt >= {1'b0, i_end_addr});

  // State, burst length and in-burst beat index registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  // Burst start/finish decisions; a full burst beats a flush burst
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (i_en && (bus.i_fifo_rd_cnt >= BURST_LEN_C)) begin
          state_d = BURST;
          len_d   = BURST_LEN_C;
          beat_d  = '0;
        end else if (i_en && i_flush && !bus.i_fifo_empty) begin
          state_d = BURST;
          // FWFT count can trail the empty flag by a cycle; never latch a
          // zero-length burst, which would otherwise run to counter wrap.
          len_d   = (bus.i_fifo_rd_cnt == '0) ? ONE_C : bus.i_fifo_rd_cnt;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (fire) begin
          beat_d = beat_q + ONE_C;
          if (last_beat) state_d = IDLE;
        end
      end
    endcase
  end

  // Circular address pointer and one-cycle wrap pulse; loads only while idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= fire & wrap_hit;
      if ((state_q == IDLE) && i_addr_load)
        addr_q <= i_base_addr;
      else if (fire)
        addr_q <= wrap_hit ? i_base_addr : addr_nxt[ADDR_WD-1:0];
    end
  end

  // Free-running accepted-beat total, wraps modulo 2**32
  always_ff @(posedge i_clk) begin
    if (i_rst) beat_tot_q <= '0;
    else if (fire) beat_tot_q <= beat_tot_q + 32'd1;
  end

  assign bus.o_fifo_rd      = fire;
  assign bus.o_app_cmd      = 3'b000;
  assign bus.o_app_addr     = addr_q;
  assign bus.o_app_en       = fire;
  assign bus.o_app_wdf_data = bus.i_fifo_dout;
  assign bus.o_app_wdf_wren = fire;
  assign bus.o_app_wdf_end  = fire;

  assign o_busy     = (state_q == BURST);
  assign o_wrap     = wrap_q;
  assign o_beat_cnt = beat_tot_q;

endmodule

// File: tb/tb_ddr3_wr_burst_ctrl.sv
// Bench for ddr3_wr_burst_ctrl: queue-based FWFT FIFO model, random payload
// words tagged with a serial number, and a beat-level reference model for
// address walk, wrap pulse and beat totals.
module tb_ddr3_wr_burst_ctrl;
  localparam int DW = 512, AW = 28, CW = 6, BL = 16, STEP = 8;

  logic          clk = 1'b0;
  logic          rst, en, flush, addr_load;
  logic [AW-1:0] base, end_a;
  logic          busy, wrap;
  logic [31:0]   beat_cnt;

  ddr3_wr_burst_ctrl_if #(.DATA_WD(DW), .ADDR_WD(AW), .CNT_WD(CW)) ifc ();

  ddr3_wr_burst_ctrl #(.DATA_WD(DW), .ADDR_WD(AW), .CNT_WD(CW), .BURST_LEN(BL), .ADDR_STEP(STEP)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_addr_load(addr_load),
    .i_base_addr(base), .i_end_addr(end_a), .bus(ifc),
    .o_busy(busy), .o_wrap(wrap), .o_beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];          // FIFO contents, head at index 0
  logic [AW-1:0] fa[$];         // addresses of accepted beats in the current test
  logic [AW-1:0] m_addr;
  logic [31:0]   m_total;
  logic          m_wrap;
  int unsigned   ser_push, ser_exp;
  int            n_pass, n_tot, n_fail, n_fire, n0, cyc, first, last, dut_wraps;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    ifc.i_fifo_empty  = (q.size() == 0);
    ifc.i_fifo_rd_cnt = CW'(q.size());
    ifc.i_fifo_dout   = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
      w[31:0] = ser_push;
      ser_push++;
      q.push_back(w);
    end
    drive_fifo();
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then pop the FIFO model just after the rising edge if a beat was taken.
  task automatic tick();
    logic          f, wh;
    logic [AW:0]   nx;
    @(negedge clk);
    f  = ifc.o_app_en;
    wh = 1'b0;
    if (!rst) begin
      chk("strobe_eq", {ifc.o_app_wdf_wren, ifc.o_app_wdf_end, ifc.o_fifo_rd}, {3{f}});
      chk("fire_rule", f, busy & ~ifc.i_fifo_empty & ifc.i_app_rdy & ifc.i_app_wdf_rdy);
      chk("cmd", ifc.o_app_cmd, 0);
      chk("wrap", wrap, m_wrap);
      chk("beat_cnt", beat_cnt, m_total);
      if (wrap) dut_wraps++;
    end
    if (f) begin
      if (!rst) begin
        chk("pop_nonempty", q.size() != 0, 1);
        chk("addr", ifc.o_app_addr, m_addr);
        chk("data", ifc.o_app_wdf_data, (q.size() != 0) ? q[0] : '0);
        chk("order", ifc.o_app_wdf_data[31:0], ser_exp);
      end
      fa.push_back(ifc.o_app_addr);
      ser_exp++;
      m_total++;
      n_fire++;
      nx = {1'b0, m_addr} + (AW+1)'(STEP);
      if (nx >= {1'b0, end_a}) begin m_addr = base; wh = 1'b1; end
      else m_addr = nx[AW-1:0];
      if (first < 0) first = cyc;
      last = cyc;
    end
    m_wrap = wh;
    @(posedge clk);
    #1;
    if (f && q.size() != 0) void'(q.pop_front());
    if (rst) begin m_addr = '0; m_total = '0; m_wrap = 1'b0; end
    cyc++;
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input string tag, input int target, input int limit);
    int i;
    i = 0;
    while ((n_fire - n0) < target && i < limit) begin tick(); i++; end
    chk(tag, (n_fire - n0) >= target, 1);
  endtask

  task automatic load_base();
    addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
    m_addr = base;
  endtask

  task automatic start_test();
    fa.delete();
    first = -1;
    last  = -1;
    n0    = n_fire;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_tot = 0; n_fail = 0; n_fire = 0; cyc = 0; dut_wraps = 0;
    ser_push = 0; ser_exp = 0; m_addr = '0; m_total = '0; m_wrap = 1'b0;
    rst = 1'b1; en = 1'b0; flush = 1'b0; addr_load = 1'b0;
    base = '0; end_a = 28'h010_0000;
    ifc.i_app_rdy = 1'b1; ifc.i_app_wdf_rdy = 1'b1;
    drive_fifo();
    start_test();
    run(3);
    rst = 1'b0;

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_addr", ifc.o_app_addr, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_strobe", {ifc.o_app_en, ifc.o_fifo_rd, ifc.o_app_wdf_wren}, 0);

    // 1: full 16-beat burst, ready always high
    base = 28'h000_0400;
    load_base();
    push(16);
    start_test();
    en = 1'b1;
    run(22);
    chk("t1_beats", n_fire - n0, 16);
    chk("t1_contig", last - first, 15);
    chk("t1_first_addr", fa.size() > 0 ? fa[0] : '1, base);
    chk("t1_last_addr", fa.size() > 15 ? fa[15] : '1, base + 120);
    chk("t1_busy", busy, 0);
    chk("t1_beat_cnt", beat_cnt, 16);
    chk("t1_fifo_left", q.size(), 0);

    // 2: 15 words wait for flush, then drain as one short burst
    push(15);
    start_test();
    run(8);
    chk("t2_no_flush", n_fire - n0, 0);
    chk("t2_idle", busy, 0);
    flush = 1'b1;
    run(22);
    chk("t2_beats", n_fire - n0, 15);
    chk("t2_contig", last - first, 14);
    chk("t2_fifo_left", q.size(), 0);
    chk("t2_busy", busy, 0);
    flush = 1'b0;

    // 3: random back-pressure on both MIG channels
    push(16);
    start_test();
    for (int i = 0; i < 400 && (n_fire - n0) < 16; i++) begin
      ifc.i_app_rdy     = ($urandom_range(0, 2) != 0);
      ifc.i_app_wdf_rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    ifc.i_app_rdy = 1'b1; ifc.i_app_wdf_rdy = 1'b1;
    run(3);
    chk("t3_beats", n_fire - n0, 16);
    chk("t3_fifo_left", q.size(), 0);
    chk("t3_busy", busy, 0);

    // 4: 16-beat region, 32 beats -> two wraps, beat 16 back at base
    en = 1'b0;
    run(2);
    base = 28'h100; end_a = 28'h180;
    load_base();
    push(32);
    start_test();
    dut_wraps = 0;
    en = 1'b1;
    run(45);
    chk("t4_beats", n_fire - n0, 32);
    chk("t4_wraps", dut_wraps, 2);
    chk("t4_beat15_addr", fa.size() > 15 ? fa[15] : '1, 28'h178);
    chk("t4_beat16_addr", fa.size() > 16 ? fa[16] : '1, 28'h100);
    chk("t4_idle_gap", (last - first) >= 32, 1);

    // 5: reset in the middle of a burst, then restart from a loaded base
    en = 1'b0;
    run(2);
    base = 28'h2000; end_a = 28'h4000;
    load_base();
    push(16);
    start_test();
    en = 1'b1;
    run_to("t5_reach_beat5", 5, 30);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_strobe", {ifc.o_app_en, ifc.o_fifo_rd, ifc.o_app_wdf_wren}, 0);
    chk("t5_addr", ifc.o_app_addr, 0);
    chk("t5_beat_cnt", beat_cnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_fifo_kept", q.size(), 10);
    load_base();
    push(6);
    start_test();
    en = 1'b1;
    run(25);
    chk("t5_beats", n_fire - n0, 16);
    chk("t5_restart_addr", fa.size() > 0 ? fa[0] : '1, 28'h2000);
    chk("t5_beat_cnt_after", beat_cnt, 16);

    // 6: drop enable mid-burst; address load during the burst is ignored
    en = 1'b0;
    run(2);
    push(40);
    start_test();
    en = 1'b1;
    run_to("t6_reach_beat3", 3, 20);
    en = 1'b0;
    addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
    run(45);
    chk("t6_beats", n_fire - n0, 16);
    chk("t6_fifo_left", q.size(), 24);
    chk("t6_busy", busy, 0);
    chk("t6_addr_after", ifc.o_app_addr, 28'h2000 + 32 * STEP);
    chk("t6_beat_cnt", beat_cnt, 32);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
